// File: rtl/inst_rom.sv
// Instruction ROM: zero-fills itself after reset, accepts program loads once ready, and serves
// one fetch per cycle with 1-cycle registered latency. There is no backpressure; fetches made before ready return NOP.
module inst_rom #(
    parameter int          AW       = 10,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [31:0]   addr,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic [1:0]    fault,
    output logic          ready,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic {INIT, READY} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] init_cnt, init_cnt_nxt;

    logic [31:0]   mem [DEPTH];
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;

    logic [AW-1:0] index;
    logic          misaligned;
    logic          out_of_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // The single write port is shared between the zero-fill sweep and program loads.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        we           = 1'b0;
        wa           = ld_addr;
        wd           = ld_data;
        if (!rst) begin
            case (state)
                INIT: begin
                    we           = 1'b1;
                    wa           = init_cnt;
                    wd           = 32'h0;
                    init_cnt_nxt = init_cnt + 1'b1;
                    if (&init_cnt)
                        state_nxt = READY;
                end
                READY: begin
                    we = ld_en;
                end
                default: begin
                    state_nxt = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    assign index        = addr[AW+1:2];
    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_range = ((addr >> (AW + 2)) != 32'h0);

    // The read sits in its own block, so a same-edge load to the fetched word returns the old data.
    always_ff @(posedge clk) begin
        if (rst || state != READY || !ce) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            fault      <= FAULT_NONE;
        end else if (misaligned) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            fault      <= FAULT_ALIGN;
        end else if (out_of_range) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            fault      <= FAULT_RANGE;
        end else begin
            inst       <= mem[index];
            inst_valid <= 1'b1;
            fault      <= FAULT_NONE;
        end
    end

    assign ready = (state == READY);

endmodule

// File: tb/tb_inst_rom.sv
// Bench for inst_rom (AW=4): scoreboard fed by a behavioural model, drained by a negedge monitor.
module tb_inst_rom;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst, ce, ld_en;
    logic [31:0]   addr, ld_data;
    logic [AW-1:0] ld_addr;
    logic [31:0]   inst;
    logic          inst_valid, ready;
    logic [1:0]    fault;

    typedef struct packed {
        logic [31:0] inst;
        logic        vld;
        logic [1:0]  fault;
        logic        rdy;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          ref_cnt = 0;
    int          checks  = 0;
    int          fails   = 0;
    int          cyc     = 0;

    inst_rom #(.AW(AW), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr),
        .inst(inst), .inst_valid(inst_valid), .fault(fault), .ready(ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    // Model: after reset the memory reads as all-zero once 16 non-reset edges have passed.
    task automatic step(input logic r, input logic c, input logic [31:0] a,
                        input logic le, input logic [3:0] la, input logic [31:0] ld);
        exp_t        e;
        int unsigned ua;
        rst = r; ce = c; addr = a; ld_en = le; ld_addr = la; ld_data = ld;
        ua = a;
        e  = '{inst: NOP, vld: 1'b0, fault: 2'b00, rdy: 1'b0};
        if (r) begin
            ref_cnt = 0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        end else if (ref_cnt < DEPTH) begin
            ref_cnt++;
            e.rdy = (ref_cnt == DEPTH);
        end else begin
            e.rdy = 1'b1;
            if (c) begin
                if (ua % 4 != 0)              e.fault = 2'b01;
                else if (ua >= DEPTH * 4)     e.fault = 2'b10;
                else begin
                    e.inst = ref_mem[ua / 4];
                    e.vld  = 1'b1;
                end
            end
            if (le) ref_mem[la] = ld;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b0, 1'b1, a, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic load(input logic [3:0] la, input logic [31:0] d);
        step(1'b0, 1'b0, 32'h0, 1'b1, la, d);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (inst !== e.inst || inst_valid !== e.vld || fault !== e.fault || ready !== e.rdy) begin
                    fails++;
                    $display("FAIL out@cyc%0d: got inst=%h vld=%b fault=%b ready=%b, want inst=%h vld=%b fault=%b ready=%b",
                             cyc, inst, inst_valid, fault, ready, e.inst, e.vld, e.fault, e.rdy);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] a;
        int          cls;
        // Reset, including ce/ld_en activity while rst is high.
        step(1'b1, 1'b1, 32'h0, 1'b1, 4'd1, 32'h11111111);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
        // Zero-fill with ce=1, addr=0; loads attempted during INIT must be dropped.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 32'h0, (i % 3 == 0), 4'd2, 32'h12345678);
        fetch(32'h0);
        fetch(32'h8);
        // Load then fetch word 3.
        load(4'd3, 32'h3402000A);
        fetch(32'h0000000C);
        // Fault classes and priority.
        fetch(32'h00000006);
        fetch(32'h00000040);
        fetch(32'h00000042);
        fetch(32'h80000000);
        fetch(32'h0000003C);
        step(1'b0, 1'b0, 32'h0000000C, 1'b0, 4'd0, 32'h0);
        // Same-edge load and fetch of word 5: old value first, new value next.
        step(1'b0, 1'b1, 32'h14, 1'b1, 4'd5, 32'hAAAA5555);
        fetch(32'h14);
        // Fill then stream sequential PCs, resetting mid-stream.
        for (int i = 0; i < DEPTH; i++) load(i[3:0], 32'hC0DE0000 + i);
        for (int i = 0; i < DEPTH; i++) fetch(i * 4);
        for (int i = 0; i < 5; i++) fetch(i * 4);
        step(1'b1, 1'b1, 32'h14, 1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 6; i++) fetch(32'h18 + i * 4);
        // Reset again mid-INIT, then let it finish.
        step(1'b1, 1'b1, 32'h0, 1'b0, 4'd0, 32'h0);
        for (int i = 0; i < DEPTH + 2; i++) fetch(32'h0);
        fetch(32'h14);
        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            cls = $urandom_range(0, 9);
            case (cls)
                0, 1:    a = {$urandom_range(0, 15), 2'b00} | ($urandom_range(1, 3));
                2:       a = {$urandom, 2'b00} | 32'h00000040;
                3:       a = $urandom | 32'h00000041;
                default: a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            endcase
            step($urandom_range(0, 149) == 0, $urandom_range(0, 4) != 0, a,
                 $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter AW, default 10, SHALL set the word-address width; memory depth is 2^AW 32-bit words.
REQ-002 Parameter NOP_INST, default 32'h00000000, SHALL be the instruction returned when no valid fetch is served.
REQ-003 clk  input  1  SHALL be the clock; every register updates on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 ce  input  1  SHALL be the fetch request enable from the PC stage; 1 = fetch addr this cycle.
REQ-006 addr  input  32  SHALL be the fetch byte address (PC).
REQ-007 inst  output  32  SHALL carry the fetched instruction, registered.
REQ-008 inst_valid  output  1  SHALL flag that inst holds a served fetch, registered.
REQ-009 fault  output  2  SHALL report the fetch error, registered: 00 none, 01 misaligned, 10 out of range.
REQ-010 ready  output  1  SHALL be high once initialisation completes.
REQ-011 ld_en  input  1  SHALL be the program-load write strobe.
REQ-012 ld_addr  input  AW  SHALL be the program-load word address.
REQ-013 ld_data  input  32  SHALL be the program-load write data.

Function
REQ-014 The FSM SHALL have two states, INIT and READY; INIT is entered on reset.
REQ-015 In INIT, a counter SHALL write 32'h0 to word 0, 1, ... 2^AW-1, one word per cycle.
REQ-016 In INIT, after word 2^AW-1 is written, the FSM SHALL move to READY on the next edge; INIT lasts exactly 2^AW cycles.
REQ-017 ready SHALL equal (state == READY), registered with the state.
REQ-018 In INIT, ld_en SHALL be ignored; the load is dropped, not queued.
REQ-019 In INIT, a fetch SHALL return inst=NOP_INST, inst_valid=0, fault=00.
REQ-020 In READY, ld_en=1 SHALL write ld_data to word ld_addr at that edge.
REQ-021 In READY, with ce=1, the fetch SHALL be served with exactly 1-cycle latency: a request at edge N gives inst/inst_valid/fault after edge N+1.
REQ-022 Word index SHALL be addr[AW+1:2].
REQ-023 Misaligned fetch (addr[1:0] != 0) SHALL give inst=NOP_INST, inst_valid=0, fault=01.
REQ-024 Out-of-range fetch (any of addr[31:AW+2] != 0, aligned) SHALL give inst=NOP_INST, inst_valid=0, fault=10.
REQ-025 Misaligned SHALL take priority over out of range when both apply.
REQ-026 A legal fetch SHALL give inst=mem[index], inst_valid=1, fault=00.
REQ-027 ce=0 in READY SHALL give inst=NOP_INST, inst_valid=0, fault=00 on the next cycle.
REQ-028 A load and a fetch to the same word at the same edge SHALL return the old contents (read-first); the new value is visible from the next fetch.
REQ-029 Back-to-back fetches SHALL be served every cycle with no bubbles.

Reset
REQ-030 rst=1 at an edge SHALL set state=INIT, the init counter to 0, inst=NOP_INST, inst_valid=0, fault=00 and ready=0.
REQ-031 Reset asserted mid-INIT or mid-READY SHALL restart initialisation from word 0; all prior memory contents are lost.
REQ-032 During rst=1 SHALL perform no memory writes and ignore ld_en and ce.

Verification
REQ-033 With AW=4: release reset, hold ce=1, addr=0 -> ready rises after exactly 16 cycles; inst_valid=0 throughout INIT; first valid inst=32'h0.
REQ-034 In READY: load word 3=32'h3402000A; fetch addr=32'h0000000C -> next cycle inst=32'h3402000A, inst_valid=1, fault=00.
REQ-035 In READY: fetch addr=32'h00000006 -> fault=01, inst_valid=0; fetch addr=32'h00000040 (AW=4) -> fault=10; fetch addr=32'h00000042 -> fault=01.
REQ-036 In READY: same edge, load word 5=32'hAAAA5555 and fetch addr=32'h14 (old value 0) -> inst=32'h0; refetch next cycle -> 32'hAAAA5555.
REQ-037 Fetch PC sequence 0,4,8,... with ce=1 every cycle -> inst_valid=1 every cycle after the first, data in order; assert rst mid-stream -> ready=0 next cycle, inst_valid=0, reload needed.
